// File: rtl/coin_purse.sv
// ---------------------------------------------------------------------------
// coin_purse
//
// Purpose:
//   A coin purse that buys beverages from a vending machine. The purse holds
//   nickels, dimes and quarters. On a buy request it pays the machine five
//   nickel-equivalents, one coin per cycle, choosing each coin by a fixed
//   policy. It then waits for the machine to finish the sale. Coins that the
//   machine returns as change go back into the purse inventory.
//
// Optional feature:
//   PURSE_WDOG_EN  When defined, a 4-bit watchdog runs while waiting for the
//                  machine. After 15 cycles without completion the
//                  transaction is aborted and an error pulse is raised. When
//                  undefined, the wait lasts indefinitely.
//
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   buy        in   purchase request, sampled only when idle
//   enable     in   machine is accepting coins
//   change     in   coin returned by the machine (0 none, 1 nickel, 2 dime,
//                   3 quarter)
//   beverage   in   beverage released this cycle
//   deposit    out  coin offered to the machine (registered)
//   busy       out  transaction in progress
//   done       out  one-cycle pulse at transaction end
//   refunded   out  pulses with done when no beverage was received
//   error      out  one-cycle pulse on a rejected buy or a watchdog abort
//   n5/n10/n25 out  current coin inventory
//   bev_count  out  beverages received since reset (wraps at 255)
// ---------------------------------------------------------------------------
module coin_purse #(
    parameter int BITS   = 4,
    parameter int INIT5  = 4,
    parameter int INIT10 = 4,
    parameter int INIT25 = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            buy,
    input  logic            enable,
    input  logic [1:0]      change,
    input  logic            beverage,
    output logic [1:0]      deposit,
    output logic            busy,
    output logic            done,
    output logic            refunded,
    output logic            error,
    output logic [BITS-1:0] n5,
    output logic [BITS-1:0] n10,
    output logic [BITS-1:0] n25,
    output logic [7:0]      bev_count
);

    localparam logic [1:0] COIN_NONE    = 2'd0;
    localparam logic [1:0] COIN_NICKEL  = 2'd1;
    localparam logic [1:0] COIN_DIME    = 2'd2;
    localparam logic [1:0] COIN_QUARTER = 2'd3;

    // Wide enough for n5 + 2*n10 + 5*n25 at full counters.
    localparam int VW = BITS + 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PAY  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      deposit_q, deposit_d;
    logic [3:0]      paid_q, paid_d;
    logic            bev_seen_q, bev_seen_d;
    logic            low_seen_q, low_seen_d;
    logic            done_q, done_d;
    logic            refunded_q, refunded_d;
    logic            error_q, error_d;
    logic [7:0]      bev_count_q, bev_count_d;
`ifdef PURSE_WDOG_EN
    logic [3:0]      wdog_q, wdog_d;
`endif

    logic [1:0]      spend;        // coin leaving the purse on this edge
    logic [1:0]      pick;         // coin the policy would pay next
    logic [3:0]      rem;          // nickel-equivalents still owed
    logic [VW-1:0]   value;        // total inventory value
    logic [BITS-1:0] inv [3];      // index 0 nickel, 1 dime, 2 quarter

    function automatic logic [3:0] coin_value(input logic [1:0] coin);
        case (coin)
            COIN_NICKEL:  coin_value = 4'd1;
            COIN_DIME:    coin_value = 4'd2;
            COIN_QUARTER: coin_value = 4'd5;
            default:      coin_value = 4'd0;
        endcase
    endfunction

    // -----------------------------------------------------------------------
    // Inventory counters, one per denomination. A coin paid out and a coin
    // of the same kind returned on the same edge cancel. Returns saturate.
    // -----------------------------------------------------------------------
    for (genvar gi = 0; gi < 3; gi++) begin : g_inv
        localparam logic [BITS-1:0] INIT_V = (gi == 0) ? BITS'(INIT5)  :
                                             (gi == 1) ? BITS'(INIT10) :
                                                         BITS'(INIT25);
        localparam logic [1:0] CODE = 2'(gi + 1);

        logic [BITS-1:0] cnt_q, cnt_d;
        logic            inc, dec;

        assign inc = (change == CODE);
        assign dec = (spend == CODE);

        always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec) begin
                if (cnt_q != {BITS{1'b1}}) begin
                    cnt_d = cnt_q + BITS'(1);
                end
            end else if (dec && !inc) begin
                cnt_d = cnt_q - BITS'(1);
            end
        end

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                cnt_q <= INIT_V;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign inv[gi] = cnt_q;
    end

    assign value = VW'(inv[0]) + (VW'(inv[1]) << 1) + VW'(inv[2]) * VW'(5);

    // -----------------------------------------------------------------------
    // Coin selection. A quarter is only used for a fresh payment so no
    // change is needed; otherwise prefer dimes while two or more are owed.
    // The fallbacks overpay when exact coins are missing. Because every coin
    // moves its worth from inventory into paid, inventory is never empty
    // while paid < 5, so the last fallback always has a quarter to give.
    // -----------------------------------------------------------------------
    always_comb begin
        rem = 4'd5 - paid_q;
        if (rem == 4'd5 && inv[2] != '0) begin
            pick = COIN_QUARTER;
        end else if (rem >= 4'd2 && inv[1] != '0) begin
            pick = COIN_DIME;
        end else if (inv[0] != '0) begin
            pick = COIN_NICKEL;
        end else if (inv[1] != '0) begin
            pick = COIN_DIME;
        end else begin
            pick = COIN_QUARTER;
        end
    end

    // -----------------------------------------------------------------------
    // Transaction FSM, next-state and registered-output logic.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        deposit_d   = COIN_NONE;
        paid_d      = paid_q;
        bev_seen_d  = bev_seen_q;
        low_seen_d  = low_seen_q;
        done_d      = 1'b0;
        refunded_d  = 1'b0;
        error_d     = 1'b0;
        bev_count_d = bev_count_q;
        spend       = COIN_NONE;
`ifdef PURSE_WDOG_EN
        wdog_d      = 4'd0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (buy) begin
                    if (value >= VW'(5)) begin
                        state_d    = ST_PAY;
                        paid_d     = 4'd0;
                        bev_seen_d = 1'b0;
                        low_seen_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            ST_PAY: begin
                if (paid_q >= 4'd5) begin
                    state_d = ST_WAIT;
                end else if (enable) begin
                    deposit_d = pick;
                    spend     = pick;
                    paid_d    = paid_q + coin_value(pick);
                end
            end

            ST_WAIT: begin
                if (!enable) begin
                    low_seen_d = 1'b1;
                end
                if (beverage) begin
                    bev_seen_d  = 1'b1;
                    bev_count_d = bev_count_q + 8'd1;
                end
                // The machine signals the end of a sale by dropping enable
                // and raising it again.
                if (low_seen_q && enable) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    refunded_d = !(bev_seen_q || beverage);
                end
`ifdef PURSE_WDOG_EN
                else if (wdog_q == 4'd14) begin
                    // Fifteenth cycle in WAIT without completion.
                    state_d     = ST_IDLE;
                    error_d     = 1'b1;
                    bev_count_d = bev_count_q;
                end else begin
                    wdog_d = wdog_q + 4'd1;
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            deposit_q   <= COIN_NONE;
            paid_q      <= 4'd0;
            bev_seen_q  <= 1'b0;
            low_seen_q  <= 1'b0;
            done_q      <= 1'b0;
            refunded_q  <= 1'b0;
            error_q     <= 1'b0;
            bev_count_q <= 8'd0;
`ifdef PURSE_WDOG_EN
            wdog_q      <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            deposit_q   <= deposit_d;
            paid_q      <= paid_d;
            bev_seen_q  <= bev_seen_d;
            low_seen_q  <= low_seen_d;
            done_q      <= done_d;
            refunded_q  <= refunded_d;
            error_q     <= error_d;
            bev_count_q <= bev_count_d;
`ifdef PURSE_WDOG_EN
            wdog_q      <= wdog_d;
`endif
        end
    end

    assign deposit   = deposit_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = done_q;
    assign refunded  = refunded_q;
    assign error     = error_q;
    assign n5        = inv[0];
    assign n10       = inv[1];
    assign n25       = inv[2];
    assign bev_count = bev_count_q;

endmodule
